// File: rtl/sigmoid_stream.sv
// Two-stage streaming sigmoid: scores are scaled, mapped to probabilities
// (PWL / hard / step), tagged with a channel index and reduced to a frame argmax.
module sigmoid_stream #(
  parameter int W     = 8,
  parameter int FRAC  = 6,
  parameter int SHIFT = 6,
  parameter int NCH   = 2,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W+4:0] in_z,
  input  logic                in_last,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_p,
  output logic [CW-1:0]       out_ch,
  output logic                out_last,
  output logic                out_sat,
  output logic [CW-1:0]       dec_idx,
  output logic [W-1:0]        dec_p
);
  localparam int ZW = W + 5;
  localparam logic [W-1:0]  ONE     = W'(1 << FRAC);
  localparam logic [W-1:0]  HALF    = W'(1 << (FRAC - 1));
  localparam logic [W-1:0]  Q75     = W'(3 << (FRAC - 2));
  localparam logic [W-1:0]  Q875    = W'(7 << (FRAC - 3));
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  logic                 s1_vld_q, s1_vld_d;
  logic signed [ZW-1:0] s1_x_q, s1_x_d;
  logic [1:0]           s1_mode_q, s1_mode_d;
  logic                 s1_last_q, s1_last_d;
  logic [CW-1:0]        s1_ch_q, s1_ch_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_p_q, out_p_d;
  logic [CW-1:0]        out_ch_q, out_ch_d;
  logic                 out_last_q, out_last_d;
  logic                 out_sat_q, out_sat_d;
  logic [CW-1:0]        dec_idx_q, dec_idx_d;
  logic [W-1:0]         dec_p_q, dec_p_d;
  logic [W-1:0]         max_p_q, max_p_d;
  logic [CW-1:0]        max_idx_q, max_idx_d;

  logic          advance, neg, big, take, s1_end;
  logic [ZW-1:0] a;
  logic [2:0]    a3;
  logic [W-1:0]  pos, p;
  logic          sat;
  logic [W-1:0]  nmax_p;
  logic [CW-1:0] nmax_idx;

  // Whole pipeline freezes only when a presented output is refused.
  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_x_d    = s1_x_q;
    s1_mode_d = s1_mode_q;
    s1_last_d = s1_last_q;
    s1_ch_d   = s1_ch_q;
    cnt_d     = cnt_q;
    s1_end    = in_last || (cnt_q == LAST_CH);
    if (advance) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_x_d    = in_z >>> SHIFT;
        s1_mode_d = in_mode;
        s1_last_d = s1_end;
        s1_ch_d   = cnt_q;
        cnt_d     = s1_end ? '0 : cnt_q + CW'(1);
      end
    end
  end

  // Magnitude below 8 fits in three bits, which is all the segments need.
  always_comb begin
    neg = s1_x_q[ZW-1];
    a   = neg ? -s1_x_q : s1_x_q;
    a3  = a[2:0];
    big = (a >= ZW'(8));
    pos = ONE;
    p   = '0;
    sat = 1'b0;
    case (s1_mode_q)
      2'b01: begin
        sat = big;
        if (big)      p = neg ? '0 : ONE;
        else if (neg) p = HALF - (W'(a3) << (FRAC - 4));
        else          p = HALF + (W'(a3) << (FRAC - 4));
      end
      2'b10: p = neg ? '0 : ONE;
      default: begin
        if (big)                 pos = ONE;
        else if (a <= ZW'(2))    pos = HALF + (W'(a3) << (FRAC - 3));
        else if (a <= ZW'(6))    pos = Q75 + (W'(a3 - 3'd2) << (FRAC - 5));
        else                     pos = Q875 + (W'(a3 - 3'd6) << (FRAC - 4));
        p   = neg ? ONE - pos : pos;
        sat = big;
      end
    endcase
  end

  // Channel 0 always opens a frame, so it seeds the tracker; strict > keeps ties low.
  always_comb begin
    take     = (s1_ch_q == '0) || (p > max_p_q);
    nmax_p   = take ? p : max_p_q;
    nmax_idx = take ? s1_ch_q : max_idx_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    dec_idx_d   = dec_idx_q;
    dec_p_d     = dec_p_q;
    max_p_d     = max_p_q;
    max_idx_d   = max_idx_q;
    if (advance) begin
      out_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        out_p_d    = p;
        out_ch_d   = s1_ch_q;
        out_last_d = s1_last_q;
        out_sat_d  = sat;
        dec_idx_d  = s1_last_q ? nmax_idx : '0;
        dec_p_d    = s1_last_q ? nmax_p : '0;
        max_p_d    = s1_last_q ? '0 : nmax_p;
        max_idx_d  = s1_last_q ? '0 : nmax_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_x_q      <= '0;
      s1_mode_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_ch_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      dec_idx_q   <= '0;
      dec_p_q     <= '0;
      max_p_q     <= '0;
      max_idx_q   <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_x_q      <= s1_x_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s1_ch_q     <= s1_ch_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      dec_idx_q   <= dec_idx_d;
      dec_p_q     <= dec_p_d;
      max_p_q     <= max_p_d;
      max_idx_q   <= max_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;
  assign dec_idx   = dec_idx_q;
  assign dec_p     = dec_p_q;
endmodule

// File: tb/tb_sigmoid_stream.sv
// Bench for sigmoid_stream: constant vector table, hand-written frame/stall/reset
// sequences, and a randomized stream scored against a behavioural model.
module tb_sigmoid_stream;
  localparam int W = 8, FRAC = 6, SHIFT = 6, NCH = 2, CW = 4, ZW = W + 5;
  localparam int ONE = 1 << FRAC;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, in_last, out_valid, out_ready;
  logic                 out_last, out_sat;
  logic signed [ZW-1:0] in_z;
  logic [1:0]           in_mode;
  logic [W-1:0]         out_p, dec_p;
  logic [CW-1:0]        out_ch, dec_idx;

  sigmoid_stream #(.W(W), .FRAC(FRAC), .SHIFT(SHIFT), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .in_last(in_last), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_ch(out_ch), .out_last(out_last), .out_sat(out_sat),
    .dec_idx(dec_idx), .dec_p(dec_p));

  always #5 clk = ~clk;

  typedef struct { int p; int ch; int last; int sat; int didx; int dp; } beat_t;
  typedef struct { int z; int mode; int p; int sat; } vec_t;

  beat_t exp_q[$], obs_q[$];
  int    npass = 0, ntot = 0;
  int    mch = 0, mmax_p = 0, mmax_i = 0;
  int    rmode = 0, pidx = 0;
  bit [3:0] pat = 4'b1001;

  task automatic chk(input string name, input int got, input int expv);
    ntot++;
    if (got == expv) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, expv);
  endtask

  function automatic int floordiv(input int z);
    int d, q;
    d = 1 << SHIFT;
    q = z / d;
    if (z < 0 && q * d != z) q--;
    return q;
  endfunction

  // Probability in units of 1/ONE, straight from the segment definitions.
  function automatic void ref_p(input int z, input int mode, output int p, output int sat);
    int x, a, v;
    x = floordiv(z);
    a = (x < 0) ? -x : x;
    if (mode == 2) begin
      p = (x >= 0) ? ONE : 0; sat = 0;
    end else if (mode == 1) begin
      v = ONE / 2 + x * ONE / 16;
      if (v > ONE) v = ONE;
      if (v < 0) v = 0;
      p = v; sat = (a >= 8) ? 1 : 0;
    end else begin
      if (a <= 2)      v = ONE / 2 + a * ONE / 8;
      else if (a <= 6) v = ONE * 3 / 4 + (a - 2) * ONE / 32;
      else if (a < 8)  v = ONE * 7 / 8 + (a - 6) * ONE / 16;
      else             v = ONE;
      p = (x < 0) ? ONE - v : v; sat = (a >= 8) ? 1 : 0;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[pidx % 4]; pidx++; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Negedge scoreboard: model on accept, compare on emit, hold-check on stall.
  logic [14:0] held;
  bit          stall_prev = 0;
  initial begin
    beat_t e, o;
    int p, s;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete(); mch = 0; mmax_p = 0; mmax_i = 0; stall_prev = 0;
      end else begin
        if (stall_prev)
          chk("stall_hold", int'({out_valid, out_p, out_ch, out_last, out_sat}), int'(held));
        if (out_valid && out_ready) begin
          o = '{int'(out_p), int'(out_ch), int'(out_last), int'(out_sat), int'(dec_idx), int'(dec_p)};
          obs_q.push_back(o);
          ntot++;
          if (exp_q.size() == 0) $display("FAIL beat: unexpected output p=%0d ch=%0d", o.p, o.ch);
          else begin
            e = exp_q.pop_front();
            if (o == e) npass++;
            else $display("FAIL beat: got p=%0d ch=%0d last=%0d sat=%0d dec=%0d/%0d, expected p=%0d ch=%0d last=%0d sat=%0d dec=%0d/%0d",
                          o.p, o.ch, o.last, o.sat, o.didx, o.dp, e.p, e.ch, e.last, e.sat, e.didx, e.dp);
          end
        end
        stall_prev = out_valid && !out_ready;
        held = {out_valid, out_p, out_ch, out_last, out_sat};
        if (in_valid && in_ready) begin
          ref_p(int'(in_z), int'(in_mode), p, s);
          e.p = p; e.sat = s; e.ch = mch;
          e.last = (in_last || mch == NCH - 1) ? 1 : 0;
          if (mch == 0 || p > mmax_p) begin mmax_p = p; mmax_i = mch; end
          e.didx = e.last ? mmax_i : 0;
          e.dp   = e.last ? mmax_p : 0;
          mch    = e.last ? 0 : mch + 1;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int z, input int mode, input bit last);
    bit acc = 0;
    in_valid = 1'b1; in_z = ZW'(z); in_mode = 2'(mode); in_last = last;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && k < 500) begin tick(1); k++; end
    if (k >= 500) chk("drain_timeout", 0, 1);
    tick(2);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl = '{'{0,0,32,0}, '{128,0,48,0}, '{384,0,56,0}, '{448,0,60,0}, '{512,0,64,1},
            '{-128,0,16,0}, '{-600,0,0,1}, '{256,1,48,0}, '{-64,2,0,0}, '{0,2,64,0},
            '{-512,1,0,1}, '{100,3,40,0}, '{200,1,44,0}};
    rst = 1'b1; in_valid = 1'b0; in_z = '0; in_mode = 2'd0; in_last = 1'b0; out_ready = 1'b1;
    tick(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_dec", int'({dec_idx, dec_p}), 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick(1);

    foreach (tbl[i]) begin
      send(tbl[i].z, tbl[i].mode, 1'b0);
      in_valid = 1'b0;
      chk("lat_early", out_valid, 0);
      tick(1);
      chk("lat_valid", out_valid, 1);
      chk($sformatf("vec%0d_p", i), out_p, tbl[i].p);
      chk($sformatf("vec%0d_sat", i), out_sat, tbl[i].sat);
      tick(2);
    end

    do_reset(); obs_q.delete();
    send(0, 0, 0); send(128, 0, 0); drain();
    chk("frame_n", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("frame_ch0", obs_q[0].ch, 0);   chk("frame_ch1", obs_q[1].ch, 1);
      chk("frame_last0", obs_q[0].last, 0); chk("frame_last1", obs_q[1].last, 1);
      chk("frame_didx", obs_q[1].didx, 1); chk("frame_dp", obs_q[1].dp, 48);
    end

    obs_q.delete();
    send(128, 0, 0); send(128, 0, 1); send(-128, 0, 1); drain();
    chk("tie_n", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("tie_didx", obs_q[1].didx, 0);  chk("tie_dp", obs_q[1].dp, 48);
      chk("single_ch", obs_q[2].ch, 0);   chk("single_last", obs_q[2].last, 1);
      chk("single_didx", obs_q[2].didx, 0); chk("single_dp", obs_q[2].dp, 16);
    end

    rmode = 1; pidx = 0; obs_q.delete();
    for (int i = 0; i < 6; i++) send(i * 100 - 250, 0, 1'b0);
    drain();
    chk("bp_count", obs_q.size(), 6);
    rmode = 0; tick(1);

    send(0, 0, 0); send(128, 0, 0); send(256, 0, 0);
    in_valid = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    obs_q.delete();
    send(64, 0, 0); drain();
    chk("midrst_n", obs_q.size(), 1);
    if (obs_q.size() == 1) chk("midrst_ch", obs_q[0].ch, 0);

    rmode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin in_valid = 1'b0; tick(1); end
      if ($urandom_range(0, 9) == 0) send($urandom_range(0, 8191) - 4096, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      else send($urandom_range(0, 1400) - 700, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
    drain();
    rmode = 0; tick(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/sigmoid_stream.md
SIGMOID_STREAM -- requirements
Module: sigmoid_stream

Interface
REQ-001 SHALL have parameter W, default 8, output probability width.
REQ-002 SHALL have parameter FRAC, default 6, fractional bits (1.0 = 1<<FRAC); FRAC>=5 and W>=FRAC+1 are required.
REQ-003 SHALL have parameter SHIFT, default 6, arithmetic right-shift applied to the input score.
REQ-004 SHALL have parameter NCH, default 2, maximum number of channels (scores) per frame; NCH>=1.
REQ-005 SHALL have parameter CW, default 4, channel index width; 2**CW>=NCH is required.
REQ-006 SHALL have ports clk (input, 1), the single clock, rising edge.
REQ-007 SHALL have port rst (input, 1); reset is synchronous and active-high.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_z (input, signed W+5, raw score), in_last (input, 1, last score of frame), in_mode (input, 2, transfer mode).
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_p (output, W, probability), out_ch (output, CW, channel index), out_last (output, 1), out_sat (output, 1, input was clipped).
REQ-010 SHALL have ports dec_idx (output, CW) and dec_p (output, W), the frame argmax, valid only on a beat with out_last=1.

Function
REQ-011 SHALL accept an input beat when in_valid&&in_ready, and emit an output beat when out_valid&&out_ready.
REQ-012 SHALL be a 2-stage pipeline: S1 registers x=in_z>>>SHIFT (floor), mode, last, channel; S2 registers out_*; latency is exactly 2 cycles from accept to out_valid with no stall.
REQ-013 SHALL stall globally: in_ready = !(out_valid && !out_ready); while stalled, all stage registers hold and out_* stays stable.
REQ-014 SHALL sustain one beat per cycle when out_ready is held high.
REQ-015 Mode 00 (PWL sigmoid), with a=|x|: a<=2 gives 0.5+a/8; 2<a<=6 gives 0.75+(a-2)/32; 6<a<8 gives 0.875+(a-6)/16; a>=8 gives 1.0. For x<0 the result is 1.0 minus the value for |x|.
REQ-016 Mode 01 (hard sigmoid): 0.5+x/16, clipped to [0,1.0].
REQ-017 Mode 10 (step): 1.0 if x>=0, else 0.
REQ-018 Mode 11 SHALL behave as mode 00.
REQ-019 SHALL use only exact integer arithmetic (shifts and adds, no rounding) and produce out_p in [0, 1<<FRAC]; out_p never wraps.
REQ-020 SHALL set out_sat=1 when the output hit a clip bound: out_p is 0 or 1.0 and, in modes 00/01, |x|>=8 (mode 01: x<=-8 or x>=8); in mode 10, out_sat=0.
REQ-021 SHALL assign out_ch from an internal channel counter: 0 on the first beat after reset or after a last beat, incremented per accepted beat.
REQ-022 SHALL force out_last=1 when in_last=1 or the counter equals NCH-1; the counter then returns to 0.
REQ-023 SHALL track the running max of out_p within a frame; ties keep the lower channel index; dec_idx/dec_p on an out_last beat include that beat.
REQ-024 SHALL reset the max tracker after each out_last beat; a single-beat frame gives dec_idx=0, dec_p=out_p.
REQ-025 SHALL drive dec_idx=0 and dec_p=0 when out_last=0.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, clear out_valid, S1 valid, channel counter and max tracker; out_p, out_ch, out_last, out_sat, dec_idx and dec_p become 0; in_ready=1 the cycle after.
REQ-027 SHALL discard beats in flight when reset is asserted mid-operation; the first frame after reset starts at channel 0.

Verification
REQ-028 Mode 00, out_ready=1, in_z SHALL map as follows (W=8, FRAC=6): 0 -> out_p=32; 128 -> 48; 384 -> 56; 448 -> 60; 512 -> 64 with sat=1; -128 -> 16; -600 -> 0 with sat=1. Each result appears 2 cycles after accept.
REQ-029 Mode 01/10: in_z=256, mode 01 -> out_p=48; in_z=-64, mode 10 -> out_p=0, sat=0; in_z=0, mode 10 -> 64.
REQ-030 Backpressure: stream 6 beats while out_ready toggles 1,0,0,1. Required: no beat lost or duplicated, out_* stable while stalled, in order.
REQ-031 Frame: NCH=2, in_last=0 throughout, scores 0 then 128. Required: out_ch 0,1; out_last on beat 2; dec_idx=1, dec_p=48.
REQ-032 Tie and early last: scores 128,128 with in_last on beat 2 -> dec_idx=0; a single beat with in_last=1 -> out_ch=0, dec_idx=0.
REQ-033 Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 next cycle, and the next beat carries out_ch=0.
